// File: rtl/seg_pkg.sv
// Shared 7-segment constants and the decoded-digit record used by the
// display drivers and the capture path.
package seg_pkg;

   // Active-low segment patterns, bit6..0 = g..a
   localparam logic [6:0] SEG_ZERO  = 7'h40;
   localparam logic [6:0] SEG_ONE   = 7'h79;
   localparam logic [6:0] SEG_TWO   = 7'h24;
   localparam logic [6:0] SEG_THREE = 7'h30;
   localparam logic [6:0] SEG_FOUR  = 7'h19;
   localparam logic [6:0] SEG_FIVE  = 7'h12;
   localparam logic [6:0] SEG_SIX   = 7'h02;
   localparam logic [6:0] SEG_SEVEN = 7'h78;
   localparam logic [6:0] SEG_EIGHT = 7'h00;
   localparam logic [6:0] SEG_NINE  = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // BCD value reported for an unrecognised pattern
   localparam logic [3:0] BCD_ERR = 4'hF;

   // Decoded view of one digit
   typedef struct packed {
      logic       err;
      logic       blank;
      logic [3:0] bcd;
   } seg_dec_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-bit segment pattern to BCD decoder with blank/error flags.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] pattern,
   output seg_dec_t   dec
);

   // Exact 7-bit match against the known glyphs; anything else is an error
   always_comb begin
      dec.err   = 1'b0;
      dec.blank = 1'b0;
      dec.bcd   = 4'd0;
      case (pattern)
         SEG_ZERO:  dec.bcd = 4'd0;
         SEG_ONE:   dec.bcd = 4'd1;
         SEG_TWO:   dec.bcd = 4'd2;
         SEG_THREE: dec.bcd = 4'd3;
         SEG_FOUR:  dec.bcd = 4'd4;
         SEG_FIVE:  dec.bcd = 4'd5;
         SEG_SIX:   dec.bcd = 4'd6;
         SEG_SEVEN: dec.bcd = 4'd7;
         SEG_EIGHT: dec.bcd = 4'd8;
         SEG_NINE:  dec.bcd = 4'd9;
         SEG_BLANK: dec.blank = 1'b1;
         default: begin
            dec.err = 1'b1;
            dec.bcd = BCD_ERR;
         end
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed 7-segment bus: synchronises the segment and
// strobe lines, waits for a stable pattern, decodes it into a per-digit
// shadow, and commits a coherent frame once every digit has been seen.
module seg_scan_capture
   import seg_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 8,
   parameter int CNT_W         = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     an_n,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     blank_out,
   output logic [DIGITS-1:0]     err_out,
   output logic                  frame_valid
);

   localparam int SW = DIGITS + 7;
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CAP_AT  = CNT_W'(STABLE_CYCLES - 2);

   logic [SW-1:0]       sync1;
   logic [SW-1:0]       s;
   logic [SW-1:0]       p;
   logic [CNT_W-1:0]    cnt;
   logic                cap;
   logic [DIGITS-1:0]   strobe;
   logic                strobe_ok;
   logic                cap_ok;
   seg_dec_t            dec;
   logic [DIGITS-1:0]   seen;
   logic [DIGITS-1:0]   seen_base;
   logic [DIGITS-1:0]   seen_next;
   logic                commit_pending;
   logic [4*DIGITS-1:0] shadow_bcd;
   logic [DIGITS-1:0]   shadow_blank;
   logic [DIGITS-1:0]   shadow_err;

   // Two-flop synchroniser plus one delayed copy; idle bus is all ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         s     <= '1;
         p     <= '1;
      end else begin
         sync1 <= {an_n, seg_in};
         s     <= sync1;
         p     <= s;
      end
   end

   // Stability counter: restarts on any change, saturates so it never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (s != p) begin
         cnt <= '0;
      end else if (cnt != CNT_SAT) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Single capture strobe per stable window; only one-hot strobes are used
   always_comb begin
      cap       = (s == p) && (cnt == CAP_AT);
      strobe    = ~s[SW-1:7];
      strobe_ok = (strobe != '0) && ((strobe & (strobe - DIGITS'(1))) == '0);
      cap_ok    = cap && strobe_ok;
      // A commit clears the mask; a capture in that same cycle opens the next frame
      seen_base = commit_pending ? '0 : seen;
      seen_next = cap_ok ? (seen_base | strobe) : seen_base;
   end

   seg_pattern_decode u_decode (
      .pattern (s[6:0]),
      .dec     (dec)
   );

   // Seen mask and the one-cycle-delayed commit request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen           <= '0;
         commit_pending <= 1'b0;
      end else begin
         seen           <= seen_next;
         commit_pending <= cap_ok && (seen_next == '1);
      end
   end

   // Per-digit shadow registers; recapture simply overwrites
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_bcd   <= '0;
         shadow_blank <= '1;
         shadow_err   <= '0;
      end else if (cap_ok) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (strobe[i]) begin
               shadow_bcd[4*i +: 4] <= dec.bcd;
               shadow_blank[i]      <= dec.blank;
               shadow_err[i]        <= dec.err;
            end
         end
      end
   end

   // Committed outputs change only on a commit, flagged by a one-cycle pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_out     <= '0;
         blank_out   <= '1;
         err_out     <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= commit_pending;
         if (commit_pending) begin
            bcd_out   <= shadow_bcd;
            blank_out <= shadow_blank;
            err_out   <= shadow_err;
         end
      end
   end

endmodule
